// File: rtl/score_pkg.sv
// score_pkg: shared types, constants and the double-dabble step for the score controller.
// Contents: bcd_state_e FSM encoding, SCORE_MAX, BCD_DIGITS, SHIFT_CYCLES, SH_W, dd_step().
package score_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} bcd_state_e;
  localparam logic [7:0] SCORE_MAX = 8'd255;
  localparam int BCD_DIGITS = 3;
  localparam int SHIFT_CYCLES = 8;
  localparam int SH_W = 4 * BCD_DIGITS + SHIFT_CYCLES;
  // One iteration: add 3 to every BCD nibble >= 5, then shift the whole register left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] t;
    t = v;
    for (int d = 0; d < BCD_DIGITS; d++)
      if (t[SHIFT_CYCLES+4*d +: 4] >= 4'd5)
        t[SHIFT_CYCLES+4*d +: 4] = t[SHIFT_CYCLES+4*d +: 4] + 4'd3;
    return {t[SH_W-2:0], 1'b0};
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 8-bit binary to 3-digit BCD converter (double dabble).
// Ports: clk, resetn (async active-low), start (request, sampled in IDLE/DONE), bin (value captured on
// acceptance), busy (LOAD/SHIFT), done (DONE: digits written at the coming edge), dig2/dig1/dig0 (result).
module bin2bcd_seq import score_pkg::*; (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);
  bcd_state_e state, state_nxt;
  logic [SH_W-1:0] sh;
  logic [3:0] cnt;
  logic take;
  assign busy = (state == LOAD) || (state == SHIFT);
  assign done = (state == DONE);
  // A new request can be taken directly out of DONE so a queued change loses no cycle.
  assign take = start && (state == IDLE || state == DONE);
  always_comb begin
    state_nxt = state;
    state_nxt = (state == LOAD) ? SHIFT :
                (state == SHIFT) ? ((cnt == 4'(SHIFT_CYCLES - 1)) ? DONE : SHIFT) :
                start ? LOAD : IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  // The capture edge enters LOAD; LOAD and SHIFT each perform one iteration, 8 in total.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sh <= '0;
      cnt <= '0;
      dig2 <= '0;
      dig1 <= '0;
      dig0 <= '0;
    end else begin
      if (take) begin
        sh <= {{(4*BCD_DIGITS){1'b0}}, bin};
        cnt <= '0;
      end else if (busy) begin
        sh <= dd_step(sh);
        cnt <= cnt + 4'd1;
      end
      if (done) {dig2, dig1, dig0} <= sh[SH_W-1:SHIFT_CYCLES];
    end
endmodule

// File: rtl/score_controller.sv
// score_controller: round-robin point arbiter, saturating 8-bit score and lagging BCD display.
// Ports: clk, resetn (async active-low), clear (sync score clear), req/pts (requesters and packed points),
// gnt (combinational one-hot grant), score, sat (sticky clamp flag), dig2/dig1/dig0 + bcd_valid (display),
// high_score (best score since reset, only when SCORE_HIGH_SCORE_EN is defined).
module score_controller import score_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int PTS_W = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*PTS_W-1:0] pts,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [7:0]               score,
  output logic                     sat,
  output logic [3:0]               dig2,
  output logic [3:0]               dig1,
  output logic [3:0]               dig0,
  output logic                     bcd_valid
`ifdef SCORE_HIGH_SCORE_EN
  ,
  output logic [7:0]               high_score
`endif
);
  localparam int RR_W = (NUM_REQ > 2) ? 2 : 1;
  logic [RR_W-1:0] rr, rr_nxt, gidx;
  logic [PTS_W-1:0] gpts;
  logic [8:0] sum;
  logic [7:0] score_nxt;
  logic found, change, pending, busy, done;
  int idx;
  // First requester found when scanning upward from rr wins.
  always_comb begin
    gnt = '0;
    gidx = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr) + k) % NUM_REQ;
      if (resetn && !clear && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx = idx[RR_W-1:0];
        found = 1'b1;
      end
    end
  end
  assign gpts = pts[gidx*PTS_W +: PTS_W];
  assign sum = {1'b0, score} + 9'(gpts);
  assign score_nxt = clear ? 8'd0 : !found ? score : sum[8] ? SCORE_MAX : sum[7:0];
  assign change = (score_nxt != score);
  assign rr_nxt = (gidx == RR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      score <= '0;
      sat <= 1'b0;
      rr <= '0;
      pending <= 1'b0;
      bcd_valid <= 1'b1;
    end else begin
      score <= score_nxt;
      sat <= clear ? 1'b0 : (sat | (found & sum[8]));
      if (found) rr <= rr_nxt;
      // A pending change is consumed whenever the converter is not mid-conversion.
      pending <= change | (pending & busy);
      bcd_valid <= change ? 1'b0 : (done && !pending) ? 1'b1 : bcd_valid;
    end
`ifdef SCORE_HIGH_SCORE_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) high_score <= '0;
    else if (score_nxt > high_score) high_score <= score_nxt;
`endif
  bin2bcd_seq u_bcd (
    .clk(clk),
    .resetn(resetn),
    .start(pending),
    .bin(score),
    .busy(busy),
    .done(done),
    .dig2(dig2),
    .dig1(dig1),
    .dig0(dig0)
  );
endmodule

// File: tb/tb_score_controller.sv
// tb_score_controller: directed self-checking bench with a digit scoreboard for score_controller.
module tb_score_controller;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic clear = 1'b0;
  logic [1:0] req = '0;
  logic [7:0] pts = '0;
  logic [1:0] gnt;
  logic [7:0] score;
  logic sat, bcd_valid;
  logic [3:0] dig2, dig1, dig0;
`ifdef SCORE_HIGH_SCORE_EN
  logic [7:0] high_score;
`endif
  int total = 0;
  int bad = 0;
  logic [11:0] sb[$];
  logic prev_valid = 1'b1;
  logic [1:0] gexp[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  always #5 clk = ~clk;

  score_controller #(.NUM_REQ(2), .PTS_W(4)) dut (
    .clk(clk),
    .resetn(resetn),
    .clear(clear),
    .req(req),
    .pts(pts),
    .gnt(gnt),
    .score(score),
    .sat(sat),
    .dig2(dig2),
    .dig1(dig1),
    .dig0(dig0),
    .bcd_valid(bcd_valid)
`ifdef SCORE_HIGH_SCORE_EN
    ,
    .high_score(high_score)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [3:0] p1, input logic [3:0] p0);
    req = r;
    pts = {p1, p0};
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (bcd_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", bcd_valid, 1'b1);
  endtask

  // Every rising bcd_valid must present the oldest expected digit triple.
  always @(negedge clk) begin
    if (bcd_valid === 1'b1 && prev_valid === 1'b0) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_pop observed=empty expected=entry digits=%h%h%h", dig2, dig1, dig0);
      end
      if (sb.size() != 0) check("sb_digits", {dig2, dig1, dig0}, sb.pop_front());
    end
    prev_valid = bcd_valid;
  end

  initial begin
    int s;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req = 2'b01;
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_score", score, 8'd0);
    check("rst_valid", bcd_valid, 1'b1);
    req = 2'b00;
    @(negedge clk) resetn = 1'b1;
    tick();
    check("idle_score", score, 8'd0);
    check("idle_sat", sat, 1'b0);
    check("idle_dig", {dig2, dig1, dig0}, 12'h000);
    check("idle_valid", bcd_valid, 1'b1);
    check("idle_gnt", gnt, 2'b00);
    // Single add of 7 and display latency.
    drive(2'b01, 4'd0, 4'd7);
    #1 check("gnt_single", gnt, 2'b01);
    tick();
    drive(2'b00, 4'd0, 4'd0);
    check("add7_score", score, 8'd7);
    check("add7_valid", bcd_valid, 1'b0);
    sb.push_back(12'h007);
    for (int k = 1; k < 10; k++) begin
      tick();
      check("valid_low", bcd_valid, 1'b0);
    end
    tick();
    check("valid_e10", bcd_valid, 1'b1);
    check("dig_007", {dig2, dig1, dig0}, 12'h007);
    // Zero-point transfer on index 1: moves rr back to 0, score unchanged.
    drive(2'b10, 4'd0, 4'd0);
    #1 check("gnt_idx1", gnt, 2'b10);
    tick();
    drive(2'b00, 4'd0, 4'd0);
    check("add0_score", score, 8'd7);
    check("add0_valid", bcd_valid, 1'b1);
    // Round robin with both requesting.
    drive(2'b11, 4'd5, 4'd3);
    s = 7;
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_gnt", gnt, gexp[i]);
      s += (gexp[i] == 2'b01) ? 3 : 5;
      tick();
      check("rr_score", score, s);
    end
    drive(2'b00, 4'd0, 4'd0);
    check("rr_total", score, 8'd23);
    sb.push_back(12'h023);
    wait_valid(30);
    // Clear priority, back-to-back adds, saturation.
    drive(2'b01, 4'd0, 4'd15);
    clear = 1'b1;
    #1 check("clr_gnt", gnt, 2'b00);
    tick();
    clear = 1'b0;
    check("clr_score", score, 8'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("b2b_score", score, 15 * (i + 1));
    end
    drive(2'b01, 4'd0, 4'd10);
    tick();
    check("score_250", score, 8'd250);
    check("sat_250", sat, 1'b0);
    drive(2'b01, 4'd0, 4'd9);
    tick();
    check("clamp_score", score, 8'd255);
    check("clamp_sat", sat, 1'b1);
    tick();
    drive(2'b00, 4'd0, 4'd0);
    check("clamp2_score", score, 8'd255);
    check("clamp2_sat", sat, 1'b1);
    sb.push_back(12'h255);
    wait_valid(30);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr2_score", score, 8'd0);
    check("clr2_sat", sat, 1'b0);
    check("clr2_valid", bcd_valid, 1'b0);
    sb.push_back(12'h000);
    wait_valid(30);
    // Change during a running conversion: 13 is never shown, 26 follows.
    drive(2'b01, 4'd0, 4'd13);
    tick();
    drive(2'b00, 4'd0, 4'd0);
    check("first13", score, 8'd13);
    tick();
    tick();
    drive(2'b01, 4'd0, 4'd13);
    tick();
    drive(2'b00, 4'd0, 4'd0);
    check("second26", score, 8'd26);
    sb.push_back(12'h026);
    for (int k = 4; k < 19; k++) begin
      tick();
      check("stale_hidden", bcd_valid, 1'b0);
    end
    tick();
    check("valid_e19", bcd_valid, 1'b1);
    check("dig_026", {dig2, dig1, dig0}, 12'h026);
    // Reset in the middle of SHIFT.
    drive(2'b01, 4'd0, 4'd15);
    tick();
    drive(2'b00, 4'd0, 4'd0);
    check("pre_rst_score", score, 8'd41);
    sb.push_back(12'h000);
    repeat (4) tick();
    #2 resetn = 1'b0;
    req = 2'b01;
    #1;
    check("mid_rst_score", score, 8'd0);
    check("mid_rst_dig", {dig2, dig1, dig0}, 12'h000);
    check("mid_rst_valid", bcd_valid, 1'b1);
    check("mid_rst_gnt", gnt, 2'b00);
`ifdef SCORE_HIGH_SCORE_EN
    check("mid_rst_high", high_score, 8'd0);
`endif
    req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    repeat (12) tick();
    check("post_rst_valid", bcd_valid, 1'b1);
    check("post_rst_dig", {dig2, dig1, dig0}, 12'h000);
    // High score survives clear.
    drive(2'b01, 4'd0, 4'd15);
    repeat (8) tick();
    drive(2'b00, 4'd0, 4'd0);
    check("hs_score120", score, 8'd120);
`ifdef SCORE_HIGH_SCORE_EN
    check("hs_120", high_score, 8'd120);
`endif
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("hs_clr_score", score, 8'd0);
    drive(2'b01, 4'd0, 4'd15);
    tick();
    tick();
    drive(2'b01, 4'd0, 4'd10);
    tick();
    drive(2'b00, 4'd0, 4'd0);
    check("hs_score40", score, 8'd40);
`ifdef SCORE_HIGH_SCORE_EN
    check("hs_keep120", high_score, 8'd120);
`endif
    sb.push_back(12'h040);
    wait_valid(30);
    repeat (2) tick();
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_controller.md
SCORE_CONTROLLER -- requirements
Module: score_controller

Interface
REQ-001 Parameter NUM_REQ, default 2, number of point requesters (2..4).
REQ-002 Parameter PTS_W, default 4, width of each requester's point value.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 clear  in  1  synchronous score clear, level-sensitive.
REQ-006 req  in  NUM_REQ  per-requester point request, held until granted.
REQ-007 pts  in  NUM_REQ*PTS_W  packed point values; slice i belongs to req[i].
REQ-008 gnt  out  NUM_REQ  one-hot grant, combinational; transfer = req[i] & gnt[i].
REQ-009 score  out  8  registered binary score.
REQ-010 sat  out  1  sticky saturation flag.
REQ-011 dig2, dig1, dig0  out  4 each  registered BCD hundreds/tens/units of last converted score.
REQ-012 bcd_valid  out  1  digits match current score.
REQ-013 high_score  out  8  best score since reset (HIGH_SCORE_EN only).

Function
REQ-014 gnt SHALL be at most one-hot, and zero when req==0 or clear==1.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer rr, and after a transfer on index i, rr becomes (i+1) mod NUM_REQ.
REQ-016 On a transfer, score SHALL update at that edge to min(score+pts[i], 255), zero-extended add, 9-bit intermediate.
REQ-017 sat SHALL set on any clamped add (sum > 255) and stay set until clear or reset.
REQ-018 clear SHALL take priority: score<=0, sat<=0, no grant, rr unchanged.
REQ-019 Any edge E that changes score (add or clear) SHALL drop bcd_valid at E; an add of 0 or clear at score 0 is no change.
REQ-020 Conversion FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-021 IDLE->LOAD when change pending; LOAD captures score and clears pending (edge E+1).
REQ-022 SHIFT runs exactly 8 double-dabble iterations (add 3 to any BCD nibble >=5, then shift left), edges E+2..E+9.
REQ-023 DONE writes dig2/dig1/dig0 and returns to IDLE at edge E+10; bcd_valid<=1 only if no change is pending, else the FSM goes to LOAD.
REQ-024 Score changes during LOAD/SHIFT/DONE SHALL set pending and never abort the running conversion; dig* hold the previous result until DONE.
REQ-025 Back-to-back transfers every cycle SHALL be accepted without stalling; only the display lags.

Reset
REQ-026 While resetn==0: score=0, sat=0, rr=0, FSM=IDLE, pending=0, dig2=dig1=dig0=0, bcd_valid=1, high_score=0, gnt=0.
REQ-027 Reset asserted mid-conversion SHALL abandon it immediately; no partial digits appear after release.

Configuration
REQ-028 Macro SCORE_HIGH_SCORE_EN defined: high_score port exists and updates each edge to max(high_score, next score), and it is unaffected by clear.
REQ-029 Macro SCORE_HIGH_SCORE_EN undefined: no high_score port or register; all other behaviour is identical.

Structure
REQ-030 Shared package score_pkg SHALL hold the FSM state enum, SCORE_MAX=8'd255, BCD_DIGITS=3 and SHIFT_CYCLES=8.
REQ-031 Conversion datapath and FSM SHALL be in sub-module bin2bcd_seq (start/busy/done handshake); arbiter and score register stay in score_controller.
REQ-032 dig* SHALL feed the existing 7-segment decoders unchanged; no segment encoding is done in this block.

Verification
REQ-033 Reset release, no req -> score=0, dig=0/0/0, bcd_valid=1, gnt=0.
REQ-034 req=2'b01, pts[0]=7, held 1 cycle at edge E -> score=7 at E; bcd_valid=0 E..E+9; dig=0/0/7, bcd_valid=1 at E+10.
REQ-035 req=2'b11 held 4 cycles, rr=0 -> gnt sequence 01,10,01,10; score is the sum of the four granted pts.
REQ-036 score=250, pts=9 -> score=255, sat=1; second add -> score stays 255, sat stays 1; clear -> score=0, sat=0.
REQ-037 Adds at E and E+3 (score 13 then 26) -> digits 0/1/3 never shown; the second conversion follows, ending at 0/2/6 with bcd_valid=1.
REQ-038 HIGH_SCORE_EN: reach 120, clear, reach 40 -> high_score=120; resetn low mid-SHIFT -> all outputs at reset values within the same cycle.
